// File: rtl/jtag_pkg.sv
// JTAG config master shared definitions.
// Sequencer states, IR opcodes and default register widths.
package jtag_pkg;

  localparam int IR_W_DEF  = 4;
  localparam int DR_W_DEF  = 8;
  localparam int TLR_TICKS = 6;

  localparam logic [3:0] IR_TAPCONFIG = 4'b0011;

  typedef enum logic [3:0] {
    TLR_SEQ,
    IDLE,
    IR_HDR,
    IR_SHIFT,
    IR_TAIL,
    DR_HDR,
    DR_SHIFT,
    DR_TAIL,
    DONE
  } jtag_state_e;

  function automatic logic is_active(jtag_state_e s);
    return !(s == IDLE || s == DONE);
  endfunction

endpackage

// File: rtl/jtag_tck_gen.sv
// TCK divider: toggles every HALF_DIV clocks while enabled.
// Strobes flag the CLK edge that will raise or lower TCK.
module jtag_tck_gen #(
  parameter int HALF_DIV = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic enable,
  output logic tck_o,
  output logic tck_rise,
  output logic tck_fall
);

  localparam int DW = $clog2(HALF_DIV + 1);
  localparam logic [DW-1:0] LAST = DW'(HALF_DIV - 1);

  logic [DW-1:0] div_q, div_d;
  logic tck_q, tck_d;
  logic wrap;

  always_comb begin
    wrap  = enable && (div_q == LAST);
    div_d = '0;
    tck_d = 1'b0;
    if (enable) begin
      div_d = wrap ? '0 : div_q + 1'b1;
      tck_d = tck_q ^ wrap;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      div_q <= '0;
      tck_q <= 1'b0;
    end else begin
      div_q <= div_d;
      tck_q <= tck_d;
    end
  end

  assign tck_o    = tck_q;
  assign tck_rise = wrap && !tck_q;
  assign tck_fall = wrap && tck_q;

endmodule

// File: rtl/jtag_config_master.sv
// JTAG initiator: TLR sync, then one IR scan plus one DR scan
// per accepted request, returning the captured DR bits.
module jtag_config_master
  import jtag_pkg::*;
#(
  parameter int IR_WIDTH = IR_W_DEF,
  parameter int DR_WIDTH = DR_W_DEF,
  parameter int HALF_DIV = 2
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic [IR_WIDTH-1:0] req_ir,
  input  logic [DR_WIDTH-1:0] req_dr,
  input  logic                req_skip_ir,
  output logic                rsp_valid,
  output logic [DR_WIDTH-1:0] rsp_dr,
  output logic                busy,
  output logic                TCK_O,
  output logic                TMS_O,
  output logic                TDI_O,
  input  logic                TDO_I
);

  localparam int MAXW = (IR_WIDTH > DR_WIDTH) ? IR_WIDTH : DR_WIDTH;
  localparam int CW   = $clog2(MAXW + 1);

  typedef logic [CW-1:0] cnt_t;

  jtag_state_e state_q, state_d;
  cnt_t cnt_q, cnt_d;
  logic [IR_WIDTH-1:0] ir_q, ir_d;
  logic [DR_WIDTH-1:0] dr_q, dr_d;
  logic [DR_WIDTH-1:0] cap_q, cap_d;
  logic [DR_WIDTH-1:0] rsp_dr_q, rsp_dr_d;
  logic tms_q, tms_d;
  logic tdi_q, tdi_d;
  logic tck_en, tck_rise, tck_fall;

  function automatic cnt_t last_tick(jtag_state_e s);
    case (s)
      TLR_SEQ:  return cnt_t'(TLR_TICKS - 1);
      IR_HDR:   return cnt_t'(3);
      IR_SHIFT: return cnt_t'(IR_WIDTH - 1);
      IR_TAIL:  return cnt_t'(1);
      DR_HDR:   return cnt_t'(2);
      DR_SHIFT: return cnt_t'(DR_WIDTH - 1);
      DR_TAIL:  return cnt_t'(1);
      default:  return '0;
    endcase
  endfunction

  function automatic jtag_state_e succ(jtag_state_e s);
    case (s)
      TLR_SEQ:  return IDLE;
      IR_HDR:   return IR_SHIFT;
      IR_SHIFT: return IR_TAIL;
      IR_TAIL:  return DR_HDR;
      DR_HDR:   return DR_SHIFT;
      DR_SHIFT: return DR_TAIL;
      DR_TAIL:  return DONE;
      default:  return IDLE;
    endcase
  endfunction

  // Idle holds TMS high: both headers open with a 1,
  // so accepting a request never moves TMS.
  function automatic logic tms_of(jtag_state_e s, cnt_t c);
    case (s)
      TLR_SEQ:            return c < cnt_t'(TLR_TICKS - 1);
      IR_HDR:             return c < cnt_t'(2);
      IR_SHIFT, DR_SHIFT: return c == last_tick(s);
      IR_TAIL, DR_HDR,
      DR_TAIL:            return c == '0;
      default:            return 1'b1;
    endcase
  endfunction

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q  <= TLR_SEQ;
      cnt_q    <= '0;
      ir_q     <= '0;
      dr_q     <= '0;
      cap_q    <= '0;
      rsp_dr_q <= '0;
      tms_q    <= 1'b1;
      tdi_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      ir_q     <= ir_d;
      dr_q     <= dr_d;
      cap_q    <= cap_d;
      rsp_dr_q <= rsp_dr_d;
      tms_q    <= tms_d;
      tdi_q    <= tdi_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    ir_d     = ir_q;
    dr_d     = dr_q;
    cap_d    = cap_q;
    rsp_dr_d = rsp_dr_q;
    unique case (state_q)
      IDLE: begin
        if (req_valid) begin
          ir_d    = req_ir;
          dr_d    = req_dr;
          cnt_d   = '0;
          state_d = req_skip_ir ? DR_HDR : IR_HDR;
        end
      end
      DONE: state_d = IDLE;
      default: begin
        if (tck_rise && state_q == DR_SHIFT)
          cap_d = {TDO_I, cap_q[DR_WIDTH-1:1]};
        if (tck_fall) begin
          if (state_q == IR_SHIFT) ir_d = ir_q >> 1;
          if (state_q == DR_SHIFT) dr_d = dr_q >> 1;
          if (cnt_q == last_tick(state_q)) begin
            state_d = succ(state_q);
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
    endcase
    if (state_q == DR_TAIL && state_d == DONE)
      rsp_dr_d = cap_q;
    tms_d = tms_of(state_d, cnt_d);
    tdi_d = (state_d == IR_SHIFT) ? ir_d[0] :
            (state_d == DR_SHIFT) ? dr_d[0] : 1'b0;
  end

  always_comb begin
    req_ready = (state_q == IDLE);
    rsp_valid = (state_q == DONE);
    busy      = !(state_q == IDLE || state_q == TLR_SEQ);
    tck_en    = is_active(state_q);
  end

  jtag_tck_gen #(
    .HALF_DIV(HALF_DIV)
  ) u_tck (
    .clk     (CLK),
    .rst     (RST),
    .enable  (tck_en),
    .tck_o   (TCK_O),
    .tck_rise(tck_rise),
    .tck_fall(tck_fall)
  );

  assign TMS_O  = tms_q;
  assign TDI_O  = tdi_q;
  assign rsp_dr = rsp_dr_q;

endmodule

// File: tb/tb_jtag_config_master.sv
// Bench: IEEE 1149.1 TAP model with an 8-bit config register
// behind TAPCONFIG, driven by jtag_config_master.
module tb_jtag_config_master;
  import jtag_pkg::*;

  localparam int HALF_DIV = 2;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic       req_valid = 1'b0;
  logic       req_ready;
  logic [3:0] req_ir = '0;
  logic [7:0] req_dr = '0;
  logic       req_skip_ir = 1'b0;
  logic       rsp_valid;
  logic [7:0] rsp_dr;
  logic       busy;
  logic       TCK_O, TMS_O, TDI_O, TDO_I;

  int checks = 0;
  int failures = 0;

  always #5 CLK = ~CLK;

  jtag_config_master #(
    .IR_WIDTH(4),
    .DR_WIDTH(8),
    .HALF_DIV(HALF_DIV)
  ) dut (
    .CLK        (CLK),
    .RST        (RST),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_ir     (req_ir),
    .req_dr     (req_dr),
    .req_skip_ir(req_skip_ir),
    .rsp_valid  (rsp_valid),
    .rsp_dr     (rsp_dr),
    .busy       (busy),
    .TCK_O      (TCK_O),
    .TMS_O      (TMS_O),
    .TDI_O      (TDI_O),
    .TDO_I      (TDO_I)
  );

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- TAP model ----------------
  typedef enum int {
    T_TLR, T_RTI, T_SELDR, T_CAPDR, T_SHDR, T_EX1DR, T_PSDR, T_EX2DR,
    T_UPDR, T_SELIR, T_CAPIR, T_SHIR, T_EX1IR, T_PSIR, T_EX2IR, T_UPIR
  } tap_e;

  tap_e       tap = T_TLR;
  logic [3:0] m_ir = 4'b0001;
  logic [3:0] m_irsr = '0;
  logic [7:0] m_cfg = 8'h01;
  logic [7:0] m_drsr = '0;
  logic [7:0] m_snap = '0;
  int         ticks = 0;
  logic       tms_hist[$];

  function automatic tap_e tap_next(tap_e s, logic tms);
    case (s)
      T_TLR:   return tms ? T_TLR   : T_RTI;
      T_RTI:   return tms ? T_SELDR : T_RTI;
      T_SELDR: return tms ? T_SELIR : T_CAPDR;
      T_CAPDR: return tms ? T_EX1DR : T_SHDR;
      T_SHDR:  return tms ? T_EX1DR : T_SHDR;
      T_EX1DR: return tms ? T_UPDR  : T_PSDR;
      T_PSDR:  return tms ? T_EX2DR : T_PSDR;
      T_EX2DR: return tms ? T_UPDR  : T_SHDR;
      T_UPDR:  return tms ? T_SELDR : T_RTI;
      T_SELIR: return tms ? T_TLR   : T_CAPIR;
      T_CAPIR: return tms ? T_EX1IR : T_SHIR;
      T_SHIR:  return tms ? T_EX1IR : T_SHIR;
      T_EX1IR: return tms ? T_UPIR  : T_PSIR;
      T_PSIR:  return tms ? T_EX2IR : T_PSIR;
      T_EX2IR: return tms ? T_UPIR  : T_SHIR;
      default: return tms ? T_SELDR : T_RTI;
    endcase
  endfunction

  // System reset doubles as TRST for the die-stack TAP.
  always @(posedge TCK_O or posedge RST) begin
    if (RST) begin
      tap  = T_TLR;
      m_ir = 4'b0001;
    end else begin
      ticks++;
      tms_hist.push_back(TMS_O);
      case (tap)
        T_CAPDR: begin
          m_drsr = (m_ir == IR_TAPCONFIG) ? m_cfg : 8'h00;
          m_snap = m_drsr;
        end
        T_SHDR:  m_drsr = {TDI_O, m_drsr[7:1]};
        T_UPDR:  if (m_ir == IR_TAPCONFIG) m_cfg = m_drsr;
        T_CAPIR: m_irsr = 4'b0001;
        T_SHIR:  m_irsr = {TDI_O, m_irsr[3:1]};
        T_UPIR:  m_ir = m_irsr;
        T_TLR:   m_ir = 4'b0001;
        default: ;
      endcase
      tap = tap_next(tap, TMS_O);
    end
  end

  assign TDO_I = (tap == T_SHDR) ? m_drsr[0] :
                 (tap == T_SHIR) ? m_irsr[0] : 1'b0;

  // ---------------- per-cycle compare ----------------
  int accepts = 0;
  int rsps = 0;

  always @(posedge CLK)
    if (!RST && req_valid && req_ready) accepts++;

  logic p_rst = 1'b1;
  logic p_tck = 1'b0, p_tms = 1'b1, p_tdi = 1'b0;
  logic [7:0] p_rsp = '0;
  int   high_len = 0;

  always @(negedge CLK) begin
    if (RST) begin
      if (p_rst) begin
        chk("rst_tck", TCK_O, 0);
        chk("rst_tms", TMS_O, 1);
        chk("rst_tdi", TDI_O, 0);
        chk("rst_ready", req_ready, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_rsp_dr", rsp_dr, 0);
        chk("rst_busy", busy, 0);
      end
      rsps = accepts;
    end else if (!p_rst) begin
      chk("pins_move_on_fall",
          ((TMS_O !== p_tms || TDI_O !== p_tdi) && !(p_tck && !TCK_O)), 0);
      chk("ready_vs_busy", busy && req_ready, 0);
      chk("tck_low_idle", req_ready && TCK_O, 0);
      if (p_tck && !TCK_O) chk("tck_high_len", high_len, HALF_DIV);
      if (rsp_valid) begin
        chk("rsp_expected", accepts, rsps + 1);
        chk("rsp_dr_model", rsp_dr, m_snap);
        chk("rsp_tap_rti", tap == T_RTI, 1);
        rsps = accepts;
      end else begin
        chk("rsp_dr_hold", rsp_dr, p_rsp);
      end
    end
    high_len = TCK_O ? (p_tck ? high_len + 1 : 1) : 0;
    p_rst = RST;
    p_tck = TCK_O;
    p_tms = TMS_O;
    p_tdi = TDI_O;
    p_rsp = rsp_dr;
  end

  // ---------------- directed tests ----------------
  task automatic wait_ready(input string name, output int n);
    n = 0;
    while (!req_ready && n < 300) begin
      @(negedge CLK);
      n++;
    end
    chk(name, req_ready, 1);
  endtask

  task automatic scan(input logic [3:0] ir, input logic [7:0] dr,
                      input logic skip, input logic hold,
                      output int nt, output logic [7:0] rsp,
                      output int wcyc, output int nacc);
    int a0, t0, n;
    a0 = accepts;
    req_ir = ir;
    req_dr = dr;
    req_skip_ir = skip;
    req_valid = 1'b1;
    wait_ready("accept_timeout", wcyc);
    @(negedge CLK);
    t0 = ticks;
    if (!hold) req_valid = 1'b0;
    n = 0;
    while (!rsp_valid && n < 1000) begin
      if (hold) begin
        chk("hold_busy", busy, 1);
        chk("hold_ready", req_ready, 0);
      end
      @(negedge CLK);
      n++;
    end
    chk("rsp_timeout", rsp_valid, 1);
    nt = ticks - t0;
    rsp = rsp_dr;
    nacc = accepts - a0;
    req_valid = 1'b0;
  endtask

  initial begin
    int nt, wc, na, n, t0;
    logic [7:0] r;
    logic [5:0] tv;

    // 1: reset and TLR sync
    repeat (3) @(negedge CLK);
    tms_hist.delete();
    t0 = ticks;
    RST = 1'b0;
    wait_ready("tlr_timeout", n);
    chk("tlr_ticks", ticks - t0, 6);
    tv = '0;
    for (int i = 0; i < 6 && i < tms_hist.size(); i++) tv[i] = tms_hist[i];
    chk("tlr_tms_seq", tv, 6'b011111);
    chk("tlr_tap_rti", tap == T_RTI, 1);

    // 2: full scan
    scan(4'h3, 8'hA5, 1'b0, 1'b0, nt, r, wc, na);
    chk("t2_ticks", nt, 23);
    chk("t2_rsp", r, 8'h01);
    chk("t2_cfg", m_cfg, 8'hA5);

    // 3: back-to-back, issued in the rsp_valid cycle
    scan(4'h3, 8'h3C, 1'b0, 1'b0, nt, r, wc, na);
    chk("t3_ready_wait", wc, 1);
    chk("t3_ticks", nt, 23);
    chk("t3_rsp", r, 8'hA5);
    chk("t3_cfg", m_cfg, 8'h3C);

    // 4: DR-only scan
    scan(4'h3, 8'hFF, 1'b1, 1'b0, nt, r, wc, na);
    chk("t4_ticks", nt, 13);
    chk("t4_rsp", r, 8'h3C);
    chk("t4_cfg", m_cfg, 8'hFF);
    chk("t4_ir_kept", m_ir, 4'h3);

    // 5: req_valid held through the scan
    scan(4'h3, 8'h5A, 1'b0, 1'b1, nt, r, wc, na);
    chk("t5_accepts", na, 1);
    chk("t5_ticks", nt, 23);
    chk("t5_rsp", r, 8'hFF);
    chk("t5_cfg", m_cfg, 8'h5A);

    // 6: reset in the middle of Shift-DR
    req_ir = 4'h3;
    req_dr = 8'h77;
    req_skip_ir = 1'b0;
    req_valid = 1'b1;
    wait_ready("t6_accept", n);
    @(negedge CLK);
    req_valid = 1'b0;
    t0 = ticks;
    n = 0;
    while ((ticks - t0) < 16 && n < 500) begin
      @(negedge CLK);
      n++;
    end
    chk("t6_in_shdr", tap == T_SHDR, 1);
    RST = 1'b1;
    @(negedge CLK);
    chk("t6_tck", TCK_O, 0);
    chk("t6_tms", TMS_O, 1);
    chk("t6_no_rsp", rsp_valid, 0);
    repeat (2) @(negedge CLK);
    t0 = ticks;
    RST = 1'b0;
    wait_ready("t6_tlr_timeout", n);
    chk("t6_tlr_ticks", ticks - t0, 6);
    chk("t6_tap_rti", tap == T_RTI, 1);
    chk("t6_cfg_kept", m_cfg, 8'h5A);
    chk("t6_rsp_dr", rsp_dr, 8'h00);
    repeat (10) @(negedge CLK);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
